// File: rtl/char_ground_detect.sv
// char_ground_detect
// Decides whether the character is supported by the floor or by one of the
// fixed platforms. Each pass latches the position once, checks one platform
// per cycle, then publishes the result with a one-cycle scan_done strobe.
// A pass is IDLE, LATCH, four SCAN cycles and UPDATE, so it takes 7 cycles.
// Dropping game_active or asserting rst mid-pass throws the pass away.
// Each PLAT_TABLE entry is {x_left, x_right, y_top}, 12 bits per field.
// Entry i sits at bits [i*36 +: 36], so platform 0 is the last item in the
// concatenation. Only a bench that needs a different table overrides it.
module char_ground_detect #(
  parameter logic [143:0] PLAT_TABLE = {
    12'd300, 12'd500, 12'd250,   // P3
    12'd700, 12'd900, 12'd350,   // P2
    12'd400, 12'd600, 12'd450,   // P1
    12'd100, 12'd300, 12'd550    // P0
  }
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] pos_x,
  input  logic [11:0] pos_y,
  input  logic [11:0] ground_lvl,
  input  logic [1:0]  game_active,
  output logic        on_ground,
  output logic        on_platform,
  output logic [1:0]  plat_id,
  output logic        scan_done
);

  localparam int CHAR_HGT = 27;
  localparam int CHAR_LNG = 19;
  localparam int TOL      = 8;
  localparam int NUM_PLAT = 4;

  localparam logic [1:0] LAST_IDX = 2'(NUM_PLAT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LATCH  = 2'd1,
    SCAN   = 2'd2,
    UPDATE = 2'd3
  } state_t;

  state_t      state;
  logic [11:0] pos_x_lat;
  logic [11:0] pos_y_lat;
  logic [11:0] ground_lat;
  logic [1:0]  scan_idx;
  logic        hit_flag;
  logic [1:0]  hit_idx;

  // Every sum and difference uses 13 bits. Twelve-bit inputs plus small
  // constants can never wrap at this width.
  logic [12:0] pos_x_ext;
  logic [12:0] feet;
  logic        run_ok;

  assign pos_x_ext = {1'b0, pos_x_lat};
  assign feet      = {1'b0, pos_y_lat} + 13'(CHAR_HGT);
  assign run_ok    = (game_active == 2'd1);

  // Build the hit test for every platform, using only the latched position.
  // SCAN then picks the result at the current index.
  logic [NUM_PLAT-1:0] plat_hit;

  for (genvar gi = 0; gi < NUM_PLAT; gi++) begin : g_plat
    localparam logic [12:0] XL = {1'b0, PLAT_TABLE[gi*36+24 +: 12]};
    localparam logic [12:0] XR = {1'b0, PLAT_TABLE[gi*36+12 +: 12]};
    localparam logic [12:0] YT = {1'b0, PLAT_TABLE[gi*36    +: 12]};

    logic x_ok;
    logic y_ok;

    // The horizontal window is widened by CHAR_LNG on both sides. Both ends
    // are inclusive.
    assign x_ok = (pos_x_ext + 13'(CHAR_LNG) >= XL) &&
                  (pos_x_ext <= XR + 13'(CHAR_LNG));
    // The feet must land in [y_top, y_top + TOL).
    assign y_ok = (feet >= YT) && (feet < YT + 13'(TOL));

    assign plat_hit[gi] = x_ok && y_ok;
  end

  logic cur_hit;
  assign cur_hit = plat_hit[scan_idx];

  // Main sequencer. It also holds the latched inputs and the registered
  // outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      scan_idx    <= 2'd0;
      hit_flag    <= 1'b0;
      hit_idx     <= 2'd0;
      pos_x_lat   <= 12'd0;
      pos_y_lat   <= 12'd0;
      ground_lat  <= 12'd0;
      on_ground   <= 1'b1;
      on_platform <= 1'b0;
      plat_id     <= 2'd0;
      scan_done   <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      case (state)
        IDLE: begin
          if (run_ok) begin
            state <= LATCH;
          end
        end

        LATCH: begin
          if (!run_ok) begin
            state <= IDLE;
          end else begin
            pos_x_lat  <= pos_x;
            pos_y_lat  <= pos_y;
            ground_lat <= ground_lvl;
            hit_flag   <= 1'b0;
            hit_idx    <= 2'd0;
            scan_idx   <= 2'd0;
            state      <= SCAN;
          end
        end

        SCAN: begin
          if (!run_ok) begin
            state <= IDLE;
          end else begin
            // The first hit wins. A later hit leaves the recorded index
            // unchanged.
            if (cur_hit && !hit_flag) begin
              hit_flag <= 1'b1;
              hit_idx  <= scan_idx;
            end
            if (scan_idx == LAST_IDX) begin
              state <= UPDATE;
            end else begin
              scan_idx <= scan_idx + 2'd1;
            end
          end
        end

        UPDATE: begin
          on_platform <= hit_flag;
          plat_id     <= hit_flag ? hit_idx : 2'd0;
          on_ground   <= hit_flag || (pos_y_lat >= ground_lat);
          scan_done   <= 1'b1;
          state       <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_char_ground_detect.sv
// Bench for char_ground_detect. A table of position vectors and a few
// hand-written sequences push expected results into a queue. A monitor pops
// one entry for each scan_done pulse and checks the outputs and the cycle on
// which the pulse arrives.
module tb_char_ground_detect;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] pos_x, pos_y, ground_lvl;
  logic [1:0]  game_active;
  logic        on_ground, on_platform, scan_done;
  logic [1:0]  plat_id;
  logic        on_ground2, on_platform2, scan_done2;
  logic [1:0]  plat_id2;

  char_ground_detect dut (
    .clk(clk), .rst(rst), .pos_x(pos_x), .pos_y(pos_y),
    .ground_lvl(ground_lvl), .game_active(game_active),
    .on_ground(on_ground), .on_platform(on_platform),
    .plat_id(plat_id), .scan_done(scan_done)
  );

  // In this copy, P3 is replaced by a duplicate of P0, so both platforms hit
  // for the same position.
  char_ground_detect #(
    .PLAT_TABLE({12'd100, 12'd300, 12'd550,
                 12'd700, 12'd900, 12'd350,
                 12'd400, 12'd600, 12'd450,
                 12'd100, 12'd300, 12'd550})
  ) dut2 (
    .clk(clk), .rst(rst), .pos_x(pos_x), .pos_y(pos_y),
    .ground_lvl(ground_lvl), .game_active(game_active),
    .on_ground(on_ground2), .on_platform(on_platform2),
    .plat_id(plat_id2), .scan_done(scan_done2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       og;
    logic       op;
    logic [1:0] id;
    int         due;
    int         tag;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [11:0] px;
    logic [11:0] py;
    logic [11:0] gl;
    logic        og;
    logic        op;
    logic [1:0]  id;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every scan_done pulse must match the oldest outstanding
  // expectation.
  always @(negedge clk) begin
    exp_t e;
    if (scan_done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_scan_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("t%0d_on_ground", e.tag), 32'(on_ground), 32'(e.og));
        chk($sformatf("t%0d_on_platform", e.tag), 32'(on_platform), 32'(e.op));
        chk($sformatf("t%0d_plat_id", e.tag), 32'(plat_id), 32'(e.id));
        chk($sformatf("t%0d_latency", e.tag), 32'(cyc), 32'(e.due));
        $display("[TB] txn %0d: og=%0d op=%0d id=%0d at cycle %0d",
                 e.tag, on_ground, on_platform, plat_id, cyc);
      end
    end
  end

  // Drive inputs just after the falling edge, well away from the active edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Start a scan from IDLE. The next rising edge enters LATCH, so the result
  // is due 7 counted edges from now.
  task automatic start_scan(input logic [11:0] px, input logic [11:0] py,
                            input logic [11:0] gl, input logic og, input logic op,
                            input logic [1:0] id, input int tag, input bit push);
    exp_t e;
    pos_x       = px;
    pos_y       = py;
    ground_lvl  = gl;
    game_active = 2'd1;
    if (push) begin
      e.og  = og;
      e.op  = op;
      e.id  = id;
      e.due = cyc + 7;
      e.tag = tag;
      sb.push_back(e);
    end
  endtask

  task automatic wait_empty(input int tag);
    for (int k = 0; k < 30 && sb.size() != 0; k++) step();
    chk($sformatf("t%0d_outstanding", tag), 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{12'd204,  12'd689,  12'd689, 1'b1, 1'b0, 2'd0}; // floor only
    vecs[1]  = '{12'd500,  12'd423,  12'd689, 1'b1, 1'b1, 2'd1}; // P1
    vecs[2]  = '{12'd81,   12'd523,  12'd689, 1'b1, 1'b1, 2'd0}; // P0 left edge in
    vecs[3]  = '{12'd80,   12'd523,  12'd689, 1'b0, 1'b0, 2'd0}; // P0 left edge out
    vecs[4]  = '{12'd319,  12'd523,  12'd689, 1'b1, 1'b1, 2'd0}; // P0 right edge in
    vecs[5]  = '{12'd320,  12'd523,  12'd689, 1'b0, 1'b0, 2'd0}; // P0 right edge out
    vecs[6]  = '{12'd200,  12'd531,  12'd689, 1'b0, 1'b0, 2'd0}; // feet = y_top+TOL
    vecs[7]  = '{12'd200,  12'd530,  12'd689, 1'b1, 1'b1, 2'd0}; // feet = y_top+TOL-1
    vecs[8]  = '{12'd300,  12'd523,  12'd689, 1'b1, 1'b1, 2'd0}; // P0/P3 x-overlap
    vecs[9]  = '{12'd800,  12'd323,  12'd689, 1'b1, 1'b1, 2'd2}; // P2
    vecs[10] = '{12'd400,  12'd223,  12'd689, 1'b1, 1'b1, 2'd3}; // P3
    vecs[11] = '{12'd1000, 12'd100,  12'd689, 1'b0, 1'b0, 2'd0}; // airborne
    vecs[12] = '{12'd50,   12'd700,  12'd689, 1'b1, 1'b0, 2'd0}; // below floor
    vecs[13] = '{12'd4095, 12'd4095, 12'd0,   1'b1, 1'b0, 2'd0}; // extremes
    vecs[14] = '{12'd200,  12'd522,  12'd689, 1'b0, 1'b0, 2'd0}; // feet = y_top-1

    rst         = 1'b1;
    game_active = 2'd0;
    pos_x       = 12'd0;
    pos_y       = 12'd0;
    ground_lvl  = 12'd0;
    repeat (3) step();
    chk("reset_on_ground", 32'(on_ground), 32'd1);
    chk("reset_on_platform", 32'(on_platform), 32'd0);
    chk("reset_plat_id", 32'(plat_id), 32'd0);
    chk("reset_scan_done", 32'(scan_done), 32'd0);

    // Release reset with gameplay already running. The first result is due
    // 7 edges later.
    rst = 1'b0;
    start_scan(12'd204, 12'd689, 12'd689, 1'b1, 1'b0, 2'd0, 100, 1'b1);
    wait_empty(100);
    game_active = 2'd0;

    for (int i = 0; i < 15; i++) begin
      step();
      start_scan(vecs[i].px, vecs[i].py, vecs[i].gl,
                 vecs[i].og, vecs[i].op, vecs[i].id, i, 1'b1);
      wait_empty(i);
      game_active = 2'd0;
    end

    // Back-to-back passes with game_active held high repeat every 7 cycles.
    step();
    start_scan(12'd500, 12'd423, 12'd689, 1'b1, 1'b1, 2'd1, 200, 1'b1);
    begin
      exp_t e2;
      e2.og = 1'b1; e2.op = 1'b1; e2.id = 2'd1; e2.due = cyc + 14; e2.tag = 201;
      sb.push_back(e2);
    end
    wait_empty(200);
    game_active = 2'd0;

    // Abort: game_active drops during SCAN. The earlier P1 result must hold,
    // and no pulse may appear.
    step();
    start_scan(12'd204, 12'd689, 12'd689, 1'b0, 1'b0, 2'd0, 300, 1'b0);
    step();
    step();
    step();
    game_active = 2'd0;
    repeat (10) step();
    chk("abort_on_ground_held", 32'(on_ground), 32'd1);
    chk("abort_on_platform_held", 32'(on_platform), 32'd1);
    chk("abort_plat_id_held", 32'(plat_id), 32'd1);
    start_scan(12'd204, 12'd689, 12'd689, 1'b1, 1'b0, 2'd0, 301, 1'b1);
    wait_empty(301);
    game_active = 2'd0;

    // Inputs change after they are latched. The result must still be P2.
    step();
    start_scan(12'd800, 12'd323, 12'd689, 1'b1, 1'b1, 2'd2, 400, 1'b1);
    step();
    step();
    pos_x = 12'd204;
    pos_y = 12'd689;
    wait_empty(400);
    game_active = 2'd0;

    // Both P0 and the patched P3 hit in the second copy. The lower index
    // must win.
    step();
    start_scan(12'd200, 12'd523, 12'd689, 1'b1, 1'b1, 2'd0, 500, 1'b1);
    wait_empty(500);
    game_active = 2'd0;
    chk("overlap_on_platform", 32'(on_platform2), 32'd1);
    chk("overlap_plat_id", 32'(plat_id2), 32'd0);

    // Reset in the middle of a scan while on_platform is 1. The pass is
    // discarded and the outputs return to their reset values.
    step();
    start_scan(12'd800, 12'd323, 12'd689, 1'b1, 1'b1, 2'd2, 600, 1'b0);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    chk("midrst_on_ground", 32'(on_ground), 32'd1);
    chk("midrst_on_platform", 32'(on_platform), 32'd0);
    chk("midrst_plat_id", 32'(plat_id), 32'd0);
    chk("midrst_scan_done", 32'(scan_done), 32'd0);
    step();
    rst = 1'b0;
    game_active = 2'd0;
    repeat (10) step();
    start_scan(12'd400, 12'd223, 12'd689, 1'b1, 1'b1, 2'd3, 601, 1'b1);
    wait_empty(601);
    game_active = 2'd0;

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
